// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and defaults for the signed add-shift multiplier
package mult_pkg;

    localparam int N_BITS_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        ADD,
        SHIFT,
        HOLD
    } state_t;

endpackage

// File: rtl/mult_control.sv
// rtl/mult_control.sv - sequencing FSM for the signed add-shift multiplier
module mult_control
    import mult_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic ClrA,
    output logic LdB,
    output logic AddEn,
    output logic SubEn,
    output logic ShiftEn,
    output logic Busy,
    output logic Done
);

    localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(N_BITS - 1);

    state_t state;
    state_t state_next;
    logic [CW-1:0] iter_cnt;
    logic last_iter;

    assign last_iter = (iter_cnt == LAST_ITER);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            iter_cnt <= '0;
        end else begin
            state <= state_next;
            // The counter never wraps: SHIFT on the last iteration leaves for HOLD instead
            if (state == CLR)
                iter_cnt <= '0;
            else if (state == SHIFT && !last_iter)
                iter_cnt <= iter_cnt + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (Run) state_next = CLR;
            CLR:     state_next = ADD;
            ADD:     state_next = SHIFT;
            SHIFT:   state_next = last_iter ? HOLD : ADD;
            HOLD:    if (!Run) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes are decoded straight from state; ADD and IDLE also look at inputs
    always_comb begin
        ClrA    = 1'b0;
        LdB     = 1'b0;
        AddEn   = 1'b0;
        SubEn   = 1'b0;
        ShiftEn = 1'b0;
        Busy    = 1'b0;
        Done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!Run && ClearA_LoadB) begin
                    ClrA = 1'b1;
                    LdB  = 1'b1;
                end
            end
            CLR: begin
                ClrA = 1'b1;
                Busy = 1'b1;
            end
            ADD: begin
                Busy  = 1'b1;
                AddEn = M && !last_iter;
                SubEn = M && last_iter;
            end
            SHIFT: begin
                Busy    = 1'b1;
                ShiftEn = 1'b1;
            end
            HOLD: begin
                Done = 1'b1;
            end
            default: begin
                Busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_control.sv
// tb/tb_mult_control.sv - randomized self-checking bench for mult_control with datapath model
module tb_mult_control;

    localparam int N = 8;

    logic Clk = 1'b0;
    logic Reset, Run, ClearA_LoadB, M;
    logic ClrA, LdB, AddEn, SubEn, ShiftEn, Busy, Done;

    always #5 Clk = ~Clk;

    mult_control #(.N_BITS(N)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .ClearA_LoadB(ClearA_LoadB), .M(M),
        .ClrA(ClrA), .LdB(LdB), .AddEn(AddEn), .SubEn(SubEn), .ShiftEn(ShiftEn),
        .Busy(Busy), .Done(Done)
    );

    // datapath model: X:A accumulator, B multiplier, switches feed S and B
    logic [7:0] sw;
    logic [7:0] a_r = 8'h00;
    logic [7:0] b_r = 8'h00;
    logic       x_r = 1'b0;
    logic [7:0] s_start, b_start;
    assign M = b_r[0];

    // t: -1 idle, 0 clear cycle, 1..2N iteration cycles (odd=add, even=shift), 2N+1 hold
    int t = -1;
    int total = 0;
    int bad = 0;
    bit chk_en = 0;
    bit prod_checked = 0;
    int n_add = 0, n_sub = 0, n_shift = 0, n_clr = 0;
    logic c_clra, c_ldb, c_add, c_sub, c_sh;

    function automatic logic [6:0] expect_outs(int tt, logic run, logic cl, logic m);
        logic e_ldb, e_clra, e_add, e_sub, e_sh, e_busy, e_done;
        bit odd;
        int it;
        e_ldb  = (tt < 0) && !run && cl;
        e_clra = (tt == 0) || e_ldb;
        odd    = (tt >= 1) && (tt <= 2*N) && (tt % 2 == 1);
        it     = (tt - 1) / 2;
        e_add  = odd && m && (it < N-1);
        e_sub  = odd && m && (it == N-1);
        e_sh   = (tt >= 2) && (tt <= 2*N) && (tt % 2 == 0);
        e_busy = (tt >= 0) && (tt <= 2*N);
        e_done = (tt == 2*N+1);
        return {e_clra, e_ldb, e_add, e_sub, e_sh, e_busy, e_done};
    endfunction

    always @(negedge Clk) begin
        if (chk_en) begin
            logic [6:0] exp_v, act_v;
            exp_v = expect_outs(t, Run, ClearA_LoadB, M);
            act_v = {ClrA, LdB, AddEn, SubEn, ShiftEn, Busy, Done};
            total++;
            if (act_v !== exp_v) begin
                bad++;
                $display("FAIL outs t=%0d: got %b expected %b (ClrA,LdB,AddEn,SubEn,ShiftEn,Busy,Done) at %0t",
                         t, act_v, exp_v, $time);
            end
            if (t == 2*N+1 && !prod_checked) begin
                int ps, pa;
                prod_checked = 1;
                ps = int'($signed(s_start)) * int'($signed(b_start));
                pa = int'($signed({a_r, b_r}));
                total++;
                if (pa != ps) begin
                    bad++;
                    $display("FAIL product %0d*%0d: got %0d expected %0d",
                             $signed(s_start), $signed(b_start), pa, ps);
                end
            end
            c_clra = ClrA; c_ldb = LdB; c_add = AddEn; c_sub = SubEn; c_sh = ShiftEn;
            if (AddEn) n_add++;
            if (SubEn) n_sub++;
            if (ShiftEn) n_shift++;
            if (ClrA) n_clr++;
        end
    end

    always @(posedge Clk) begin
        if (Reset) t = -1;
        else if (t < 0) begin
            if (Run) begin
                t = 0;
                s_start = sw;
                b_start = b_r;
                prod_checked = 0;
            end
        end else if (t <= 2*N) t = t + 1;
        else if (!Run) t = -1;

        if (chk_en) begin
            logic [8:0] sum;
            if (c_clra) begin a_r = 8'h00; x_r = 1'b0; end
            if (c_ldb) b_r = sw;
            if (c_add) begin
                sum = {a_r[7], a_r} + {sw[7], sw};
                {x_r, a_r} = sum;
            end
            if (c_sub) begin
                sum = {a_r[7], a_r} + {~sw[7], ~sw} + 9'd1;
                {x_r, a_r} = sum;
            end
            if (c_sh) {a_r, b_r} = {x_r, a_r, b_r[7:1]};
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!Done && lat < 100) begin
            cyc(1);
            lat++;
        end
        total++;
        if (!Done) begin
            bad++;
            $display("FAIL wait_done: got Done=%0b after %0d cycles expected Done=1", Done, lat);
        end
    endtask

    task automatic run_mult(input logic [7:0] bv, input logic [7:0] sv, input bit noise, output int lat);
        sw = bv; ClearA_LoadB = 1'b1;
        cyc(1);
        ClearA_LoadB = 1'b0; sw = sv; Run = 1'b1;
        n_add = 0; n_sub = 0; n_shift = 0; n_clr = 0;
        lat = 0;
        while (!Done && lat < 100) begin
            cyc(1);
            lat++;
            if (noise) ClearA_LoadB = 1'($urandom_range(0, 1));
        end
        ClearA_LoadB = 1'b0;
        total++;
        if (!Done) begin
            bad++;
            $display("FAIL run_mult: got Done=%0b after %0d cycles expected Done=1", Done, lat);
        end
    endtask

    initial begin
        int lat;
        Reset = 1'b1; Run = 1'b0; ClearA_LoadB = 1'b0; sw = 8'h00;
        cyc(1);
        chk_en = 1;
        cyc(1);
        Reset = 1'b0;
        #1;
        chk("reset_outs", int'({ClrA, LdB, AddEn, SubEn, ShiftEn, Busy, Done}), 0);

        sw = 8'h07; ClearA_LoadB = 1'b1;
        #1;
        chk("idle_clr_ld", int'({ClrA, LdB}), 3);
        cyc(2);
        chk("idle_clr_ld_held", int'({ClrA, LdB, Busy}), 6);
        ClearA_LoadB = 1'b0;
        cyc(1);

        run_mult(8'h07, 8'h05, 0, lat);
        chk("done_latency", lat, 18);
        chk("adds_b07", n_add, 3);
        chk("subs_b07", n_sub, 0);
        chk("shifts_b07", n_shift, 8);
        chk("product_5x7", int'({a_r, b_r}), 16'h0023);

        n_clr = 0;
        cyc(40);
        chk("hold_done", int'(Done), 1);
        chk("hold_no_clr", n_clr, 0);
        Run = 1'b0;
        cyc(1);
        Run = 1'b1;
        cyc(1);
        chk("retrigger_clr", int'({ClrA, LdB, Busy}), 5);
        wait_done(lat);
        Run = 1'b0;
        cyc(1);

        run_mult(8'h80, 8'h03, 0, lat);
        chk("subs_b80", n_sub, 1);
        chk("adds_b80", n_add, 0);
        chk("product_3x-128", int'({a_r, b_r}), 16'hFE80);
        Run = 1'b0;
        cyc(1);

        Run = 1'b1; ClearA_LoadB = 1'b1;
        #1;
        chk("run_prio_ldb", int'({ClrA, LdB}), 0);
        cyc(1);
        ClearA_LoadB = 1'b0;
        chk("run_prio_clr", int'({ClrA, LdB, Busy}), 5);
        cyc(4);
        Reset = 1'b1;
        cyc(1);
        Reset = 1'b0;
        #1;
        chk("after_reset", int'({ClrA, LdB, AddEn, SubEn, ShiftEn, Busy, Done}), 0);
        cyc(1);
        chk("restart_clr", int'({ClrA, Busy}), 3);
        wait_done(lat);
        Run = 1'b0;
        cyc(1);

        for (int i = 0; i < 25; i++) begin
            logic [7:0] bv, sv;
            bv = 8'($urandom);
            sv = 8'($urandom);
            run_mult(bv, sv, 1, lat);
            cyc($urandom_range(0, 3));
            Run = 1'b0;
            cyc(1 + $urandom_range(0, 2));
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
